// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the default operand width, imported by the RTL and the bench.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Combinational 1-bit full adder used as the single arithmetic element of
// the serial datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first,
// WIDTH cycles from start acceptance to a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-2:0] acc;        // upper bits of the partial result
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic             accept, last;

    fulladder u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = start && (state != RUN);
    assign last     = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign acc_next = {fa_sum, acc};
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= {1'b0, opa[WIDTH-1:1]};
            opb   <= {1'b0, opb[WIDTH-1:1]};
            carry <= fa_cout;
            acc   <= acc_next[WIDTH-1:1];
            cnt   <= cnt + CW'(1);
            if (last) begin
                // carry still holds the carry into the MSB on this step.
                sum  <= acc_next;
                cout <= fa_cout;
                ovf  <= carry ^ fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16: stimulus pushes
// expected results, per-instance monitors pop and compare on done.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W8  = DEFAULT_WIDTH;
    localparam int W16 = 16;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [W8-1:0] a8, b8, sum8;
    logic           start16, sub16, cin16, busy16, done16, cout16, ovf16;
    logic [W16-1:0] a16, b16, sum16;

    exp_t q8[$];
    exp_t q16[$];

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(W16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .ovf(ovf16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the true operands.
    function automatic exp_t model(input int w, input logic s, input logic c,
                                   input logic [63:0] x, input logic [63:0] y, input int t);
        exp_t        r;
        logic [63:0] mask;
        logic [63:0] yb;
        logic [64:0] full;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        yb     = s ? (~y & mask) : y;
        full   = {1'b0, x} + {1'b0, yb} + 65'(s ? 1'b1 : c);
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (x[w-1] == yb[w-1]) && (r.sum[w-1] != x[w-1]);
        r.cyc  = t;
        return r;
    endfunction

    // Drives at the current negedge; acceptance is the next posedge.
    task automatic op8(input logic s, input logic c, input logic [W8-1:0] x, input logic [W8-1:0] y);
        sub8 = s; cin8 = c; a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back(model(W8, s, c, 64'(x), 64'(y), cyc + 1 + W8));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic op16(input logic s, input logic c, input logic [W16-1:0] x, input logic [W16-1:0] y);
        sub16 = s; cin16 = c; a16 = x; b16 = y; start16 = 1'b1;
        q16.push_back(model(W16, s, c, 64'(x), 64'(y), cyc + 1 + W16));
        @(negedge clk);
        start16 = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("busy_done_excl8", 64'(busy8 & done8), 64'd0);
        if (done8) begin
            if (q8.size() == 0) begin
                check("spurious_done8", 64'(done8), 64'd0);
            end else begin
                e = q8.pop_front();
                check("sum8",  64'(sum8),  e.sum);
                check("cout8", 64'(cout8), 64'(e.cout));
                check("ovf8",  64'(ovf8),  64'(e.ovf));
                check("done_cycle8", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy16 && done16) check("busy_done_excl16", 64'(busy16 & done16), 64'd0);
        if (done16) begin
            if (q16.size() == 0) begin
                check("spurious_done16", 64'(done16), 64'd0);
            end else begin
                e = q16.pop_front();
                check("sum16",  64'(sum16),  e.sum);
                check("cout16", 64'(cout16), 64'(e.cout));
                check("ovf16",  64'(ovf16),  64'(e.ovf));
                check("done_cycle16", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_sum",  64'(sum8),  64'd0);
        check("rst_cout", 64'(cout8), 64'd0);
        check("rst_ovf",  64'(ovf8),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases at WIDTH=8.
        op8(1'b0, 1'b0, 8'hFF, 8'h01); repeat (W8 + 1) @(negedge clk);
        op8(1'b0, 1'b0, 8'h7F, 8'h01); repeat (W8 + 1) @(negedge clk);
        op8(1'b0, 1'b1, 8'h10, 8'h20); repeat (W8 + 1) @(negedge clk);
        check("hold_idle_sum", 64'(sum8), 64'h31);
        op8(1'b1, 1'b0, 8'h05, 8'h07);
        repeat (3) @(negedge clk);
        check("hold_run_sum", 64'(sum8), 64'h31);
        check("run_busy", 64'(busy8), 64'd1);
        repeat (W8 - 2) @(negedge clk);
        op8(1'b1, 1'b1, 8'h80, 8'h01); repeat (W8 + 1) @(negedge clk);

        // Start during RUN must be ignored.
        op8(1'b0, 1'b0, 8'h12, 8'h34);
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
        @(negedge clk);
        start8 = 1'b0;
        repeat (W8 - 2) @(negedge clk);

        // Back-to-back: next start issued during the DONE cycle.
        op8(1'b0, 1'b0, 8'h11, 8'h22); repeat (W8) @(negedge clk);
        op8(1'b0, 1'b0, 8'h80, 8'h80); repeat (W8 + 1) @(negedge clk);

        // Reset in the middle of an operation.
        op8(1'b0, 1'b0, 8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_sum",  64'(sum8),  64'd0);
        check("abort_cout", 64'(cout8), 64'd0);
        check("abort_ovf",  64'(ovf8),  64'd0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        op8(1'b0, 1'b0, 8'h03, 8'h04); repeat (W8 + 1) @(negedge clk);

        // Random 8-bit traffic with occasional back-to-back starts.
        for (int i = 0; i < 24; i++) begin
            int gap;
            op8(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            gap = $urandom_range(0, 3);
            repeat (W8 + gap) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // WIDTH=16 instance.
        op16(1'b0, 1'b1, 16'hFFFF, 16'h0000); repeat (W16 + 1) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            int gap;
            op16(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            gap = $urandom_range(0, 2);
            repeat (W16 + gap) @(negedge clk);
        end

        n = 0;
        while ((q8.size() + q16.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q8.size() + q16.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
